block_renderer: RTL and testbench
=================================

# block_renderer

Pixel-drawing stage directly downstream of the game logic. It consumes the block position (x, y) and game_status from the game logic, and the sync tick from the delay counter. It turns them into one-pixel-per-cycle write requests for the VGA adapter. On each frame tick it erases the block's previous image on the current row and draws the block at its new position. Blocks left on lower rows stay on screen, forming the tower. A change of game_status triggers a full-screen fill.

## Interface
- BLOCK_W, 20, block width in pixels
- BLOCK_H, 8, block height in pixels
- SCREEN_W, 160, visible columns
- SCREEN_H, 120, visible rows
- BG_COLOUR, 3'b000, background/erase colour
- BLOCK_COLOUR, 3'b111, moving-block colour
- clk  in  1  50 MHz system clock
- resetn  in  1  asynchronous, active-low reset
- sync  in  1  one-cycle frame tick from the delay counter
- x  in  8  block left column, from game logic
- y  in  7  block top row, from game logic
- game_status  in  2  00 ready, 01 playing, 10 game over, 11 won
- vga_x  out  8  pixel column to VGA adapter
- vga_y  out  7  pixel row to VGA adapter
- colour  out  3  pixel colour
- plot  out  1  pixel write strobe; vga_x, vga_y and colour are valid when high
- busy  out  1  high while clearing, erasing or drawing
- frame_done  out  1  one-cycle pulse after the last pixel of a draw or clear

## Operation
- States: CLEAR, WAIT, ERASE, DRAW.
- Reset forces state CLEAR with colour BG_COLOUR.
- Reset clears:
  - the pixel counters and pending flag;
  - last_valid (last-drawn position is invalid);
  - status register (st_q = 00).
- CLEAR:
  - Scans all SCREEN_W*SCREEN_H pixels, row-major from (0,0), one per cycle, plot=1.
  - Fill colour is latched on entry: 00→BG_COLOUR, 01→BG_COLOUR, 10→3'b100, 11→3'b010.
  - Entry sets last_valid=0.
  - The last pixel is (SCREEN_W-1, SCREEN_H-1); the next state is WAIT and frame_done pulses.
- WAIT:
  - plot=0, busy=0.
  - If game_status≠st_q: update st_q and go to CLEAR. This has priority over sync or pending.
  - Else, if (sync or pending) and st_q==01: latch x, y into nx, ny, clear pending, and go to ERASE.
  - Otherwise, sync is discarded when st_q≠01.
- ERASE:
  - Runs only if last_valid and ly==ny and lx≠nx. Otherwise it is skipped the same cycle and the block goes straight to DRAW with no lost cycle.
  - Paints the BLOCK_W×BLOCK_H rectangle at (lx, ly) in BG_COLOUR.
  - Scan order: column counter fastest, then row.
- DRAW:
  - Paints the rectangle at (nx, ny) in BLOCK_COLOUR.
  - On the last pixel: lx←nx, ly←ny, last_valid←1, then go to WAIT and pulse frame_done.
- Row change (ny≠ly): the old block is not erased, so it remains as a placed tower block.
- Clipping:
  - Any pixel with column ≥ SCREEN_W or row ≥ SCREEN_H drives plot=0 but still takes its cycle.
  - Coordinates are computed as 9-bit/8-bit sums to avoid wrap. vga_x/vga_y output the truncated value.
- sync arriving while busy sets pending. Only one pending frame is kept; further ticks are dropped.
- A game_status change during ERASE/DRAW is not acted on until WAIT. The rectangle always completes.

## Timing
- Outputs on reset: vga_x=0, vga_y=0, colour=0, plot=0, busy=1 (CLEAR), frame_done=0.
- All outputs are registered.
- Pixel (c, r) of a scan is presented in cycle k = r*W + c after state entry.
- Latency from sync to first plot: 2 cycles.
  - Cycle 1: sync sampled, position latched.
  - Cycle 2: first ERASE/DRAW pixel on outputs.
- Frame with erase: 2*BLOCK_W*BLOCK_H = 320 plot cycles. Frame without erase: 160.
- Full clear: 19200 cycles.
- frame_done is asserted in the cycle after the final plot, coincident with busy falling.

## Test plan
- Reset release, status 00 → 19200 plots of colour 000 covering (0,0)…(159,119); frame_done pulses once; busy=0 afterwards.
- status 01; sync with x=40, y=100 → no erase; 160 plots of colour 111 covering cols 40–59, rows 100–107; frame_done pulses.
- Next sync with x=44, y=100 → 160 plots of colour 000 at cols 40–59, then 160 plots of colour 111 at cols 44–63, rows 100–107.
- sync with y=92 (row change) → no erase; draw only at rows 92–99. Also pulse sync twice during the draw → exactly one extra frame follows.
- x=150 → pixels with cols 160–169 have plot=0. The scan still takes 160 cycles.
- game_status→10 mid-draw → the draw completes, then a 19200-pixel clear in 100 follows. Further syncs produce no plots until status returns to 01.

Source files
------------

// File: rtl/block_renderer.sv
// block_renderer: turns block position and game status into one-pixel-per-cycle VGA writes.
// Full-screen fill on status change; per frame tick an optional erase of the old block, then a draw.
module block_renderer #(
    parameter int          BLOCK_W      = 20,
    parameter int          BLOCK_H      = 8,
    parameter int          SCREEN_W     = 160,
    parameter int          SCREEN_H     = 120,
    parameter logic [2:0]  BG_COLOUR    = 3'b000,
    parameter logic [2:0]  BLOCK_COLOUR = 3'b111
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sync,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [1:0] game_status,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {CLEAR, WAIT, ERASE, DRAW} state_t;

    localparam logic [7:0] BW_LAST = 8'(BLOCK_W - 1);
    localparam logic [6:0] BH_LAST = 7'(BLOCK_H - 1);
    localparam logic [7:0] SW_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] SH_LAST = 7'(SCREEN_H - 1);

    state_t     state_reg, state_next;
    logic [7:0] cnt_x_reg, cnt_x_next;
    logic [6:0] cnt_y_reg, cnt_y_next;
    logic       pending_reg, pending_next;
    logic       last_valid_reg, last_valid_next;
    logic [1:0] st_q_reg, st_q_next;
    logic [7:0] nx_reg, nx_next, lx_reg, lx_next;
    logic [6:0] ny_reg, ny_next, ly_reg, ly_next;
    logic [2:0] fill_reg, fill_next;
    logic       done_reg, done_next;

    logic [7:0] vga_x_reg, vga_x_next;
    logic [6:0] vga_y_reg, vga_y_next;
    logic [2:0] colour_reg, colour_next;
    logic       plot_reg, plot_next;
    logic       busy_reg, busy_next;
    logic       frame_done_reg, frame_done_next;

    logic       do_erase;
    logic       scan_draw;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] px;
    logic [7:0] py;

    assign vga_x      = vga_x_reg;
    assign vga_y      = vga_y_reg;
    assign colour     = colour_reg;
    assign plot       = plot_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

    // An erase is only needed when the block slid sideways on the same row;
    // otherwise ERASE falls straight through to the first DRAW pixel.
    assign do_erase  = last_valid_reg && (ly_reg == ny_reg) && (lx_reg != nx_reg);
    assign scan_draw = (state_reg == DRAW) || ((state_reg == ERASE) && !do_erase);
    assign base_x    = scan_draw ? nx_reg : lx_reg;
    assign base_y    = scan_draw ? ny_reg : ly_reg;
    assign px        = {1'b0, base_x} + {1'b0, cnt_x_reg};
    assign py        = {1'b0, base_y} + {1'b0, cnt_y_reg};

    always_comb begin
        state_next      = state_reg;
        cnt_x_next      = cnt_x_reg;
        cnt_y_next      = cnt_y_reg;
        pending_next    = pending_reg;
        last_valid_next = last_valid_reg;
        st_q_next       = st_q_reg;
        nx_next         = nx_reg;
        ny_next         = ny_reg;
        lx_next         = lx_reg;
        ly_next         = ly_reg;
        fill_next       = fill_reg;
        done_next       = 1'b0;
        vga_x_next      = vga_x_reg;
        vga_y_next      = vga_y_reg;
        colour_next     = colour_reg;
        plot_next       = 1'b0;
        busy_next       = (state_reg != WAIT);
        frame_done_next = done_reg;

        if (sync && (state_reg != WAIT))
            pending_next = 1'b1;

        case (state_reg)
            CLEAR: begin
                vga_x_next  = cnt_x_reg;
                vga_y_next  = cnt_y_reg;
                colour_next = fill_reg;
                plot_next   = 1'b1;
                if (cnt_x_reg == SW_LAST) begin
                    cnt_x_next = '0;
                    if (cnt_y_reg == SH_LAST) begin
                        cnt_y_next = '0;
                        state_next = WAIT;
                        done_next  = 1'b1;
                    end else begin
                        cnt_y_next = cnt_y_reg + 7'd1;
                    end
                end else begin
                    cnt_x_next = cnt_x_reg + 8'd1;
                end
            end
            WAIT: begin
                cnt_x_next = '0;
                cnt_y_next = '0;
                if (game_status != st_q_reg) begin
                    st_q_next       = game_status;
                    last_valid_next = 1'b0;
                    state_next      = CLEAR;
                    case (game_status)
                        2'b10:   fill_next = 3'b100;
                        2'b11:   fill_next = 3'b010;
                        default: fill_next = BG_COLOUR;
                    endcase
                end else if (st_q_reg == 2'b01) begin
                    if (sync || pending_reg) begin
                        nx_next      = x;
                        ny_next      = y;
                        pending_next = 1'b0;
                        state_next   = ERASE;
                    end
                end else begin
                    pending_next = 1'b0;
                end
            end
            default: begin
                // ERASE and DRAW share the rectangle scan; scan_draw picks origin and colour.
                vga_x_next  = px[7:0];
                vga_y_next  = py[6:0];
                colour_next = scan_draw ? BLOCK_COLOUR : BG_COLOUR;
                plot_next   = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
                if (cnt_x_reg == BW_LAST) begin
                    cnt_x_next = '0;
                    if (cnt_y_reg == BH_LAST) begin
                        cnt_y_next = '0;
                        if (scan_draw) begin
                            lx_next         = nx_reg;
                            ly_next         = ny_reg;
                            last_valid_next = 1'b1;
                            state_next      = WAIT;
                            done_next       = 1'b1;
                        end else begin
                            state_next = DRAW;
                        end
                    end else begin
                        cnt_y_next = cnt_y_reg + 7'd1;
                    end
                end else begin
                    cnt_x_next = cnt_x_reg + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= CLEAR;
            cnt_x_reg      <= '0;
            cnt_y_reg      <= '0;
            pending_reg    <= 1'b0;
            last_valid_reg <= 1'b0;
            st_q_reg       <= 2'b00;
            nx_reg         <= '0;
            ny_reg         <= '0;
            lx_reg         <= '0;
            ly_reg         <= '0;
            fill_reg       <= BG_COLOUR;
            done_reg       <= 1'b0;
            vga_x_reg      <= '0;
            vga_y_reg      <= '0;
            colour_reg     <= '0;
            plot_reg       <= 1'b0;
            busy_reg       <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_x_reg      <= cnt_x_next;
            cnt_y_reg      <= cnt_y_next;
            pending_reg    <= pending_next;
            last_valid_reg <= last_valid_next;
            st_q_reg       <= st_q_next;
            nx_reg         <= nx_next;
            ny_reg         <= ny_next;
            lx_reg         <= lx_next;
            ly_reg         <= ly_next;
            fill_reg       <= fill_next;
            done_reg       <= done_next;
            vga_x_reg      <= vga_x_next;
            vga_y_reg      <= vga_y_next;
            colour_reg     <= colour_next;
            plot_reg       <= plot_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_block_renderer.sv
// Bench for block_renderer: a pixel-list model of clears and block frames is replayed
// against the DUT every cycle, plus literal latency, count and model checks.
module tb_block_renderer;

    logic       clk;
    logic       resetn;
    logic       sync;
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] game_status;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       frame_done;

    block_renderer dut (
        .clk         (clk),
        .resetn      (resetn),
        .sync        (sync),
        .x           (x),
        .y           (y),
        .game_status (game_status),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        bit mark;
        bit pl;
        int x;
        int y;
        int c;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   n_done     = 0;
    int   fplots     = 0;
    int   fbusy      = 0;
    int   last_plots = 0;
    int   last_busy  = 0;
    bit   prev_busy  = 0;
    bit   m_valid    = 0;
    int   m_lx       = 0;
    int   m_ly       = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic push_pix(input bit pl, input int px, input int py, input int c);
        exp_t e;
        e.mark = 0; e.pl = pl; e.x = px; e.y = py; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic push_mark();
        exp_t e;
        e.mark = 1; e.pl = 0; e.x = 0; e.y = 0; e.c = 0;
        exp_q.push_back(e);
    endtask

    task automatic model_rect(input int bx, input int by, input int c);
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 20; k++)
                push_pix((bx + k < 160) && (by + r < 120), bx + k, by + r, c);
    endtask

    task automatic model_clear(input logic [1:0] st);
        int fill;
        fill = (st == 2'b10) ? 4 : (st == 2'b11) ? 2 : 0;
        for (int r = 0; r < 120; r++)
            for (int k = 0; k < 160; k++)
                push_pix(1, k, r, fill);
        push_mark();
        m_valid = 0;
    endtask

    task automatic model_frame(input int nx, input int ny);
        if (m_valid && m_ly == ny && m_lx != nx)
            model_rect(m_lx, m_ly, 0);
        model_rect(nx, ny, 7);
        push_mark();
        m_lx = nx; m_ly = ny; m_valid = 1;
    endtask

    task automatic compare();
        exp_t e;
        if (busy) begin
            chk("done_while_busy", int'(frame_done), 0);
            if (exp_q.size() == 0 || exp_q[0].mark) begin
                chk("busy_vs_model", int'(busy), 0);
            end else begin
                e = exp_q.pop_front();
                chk("plot", int'(plot), int'(e.pl));
                if (e.pl) begin
                    chk("vga_x", int'(vga_x), e.x);
                    chk("vga_y", int'(vga_y), e.y);
                    chk("colour", int'(colour), e.c);
                end
            end
            fbusy++;
            if (plot) fplots++;
        end else begin
            chk("idle_plot", int'(plot), 0);
            if (frame_done) begin
                if (exp_q.size() != 0 && exp_q[0].mark)
                    e = exp_q.pop_front();
                else
                    chk("frame_done_vs_model", int'(frame_done), 0);
                last_plots = fplots;
                last_busy  = fbusy;
                fplots = 0;
                fbusy  = 0;
                n_done++;
            end else if (prev_busy) begin
                chk("frame_done_at_busy_fall", int'(frame_done), 1);
            end
        end
        prev_busy = busy;
    endtask

    task automatic step();
        @(negedge clk);
        compare();
    endtask

    task automatic wait_done(input int limit);
        int start;
        int k;
        start = n_done;
        k = 0;
        while (n_done == start && k < limit) begin
            step();
            k++;
        end
        chk("frame_timeout", n_done - start, 1);
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    initial begin
        int base;
        resetn = 1'b0;
        sync = 1'b0;
        x = 8'd0;
        y = 7'd0;
        game_status = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_vga_x", int'(vga_x), 0);
        chk("rst_vga_y", int'(vga_y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_frame_done", int'(frame_done), 0);

        // Power-up clear in background colour.
        model_clear(2'b00);
        chk("model_clear_size", exp_q.size(), 19201);
        chk("model_clear_last_x", exp_q[19199].x, 159);
        chk("model_clear_last_y", exp_q[19199].y, 119);
        resetn = 1'b1;
        wait_done(20000);
        chk("clear0_plots", last_plots, 19200);
        chk("clear0_busy", last_busy, 19200);
        repeat (3) step();

        // Status 00 -> 01 triggers another background fill.
        game_status = 2'b01;
        model_clear(2'b01);
        wait_done(20000);
        chk("clear1_plots", last_plots, 19200);

        // First block: no erase, latency of two cycles from sync.
        x = 8'd40; y = 7'd100;
        model_frame(40, 100);
        pulse_sync();
        chk("lat_idle_busy", int'(busy), 0);
        step();
        chk("lat_plot", int'(plot), 1);
        chk("lat_x", int'(vga_x), 40);
        chk("lat_y", int'(vga_y), 100);
        wait_done(400);
        chk("f1_plots", last_plots, 160);
        chk("f1_busy", last_busy, 160);
        repeat (3) step();

        // Sideways move on the same row: erase then draw.
        x = 8'd44;
        model_frame(44, 100);
        chk("model_erase_size", exp_q.size(), 321);
        chk("model_erase_x", exp_q[0].x, 40);
        chk("model_erase_c", exp_q[0].c, 0);
        chk("model_draw_x", exp_q[160].x, 44);
        chk("model_draw_c", exp_q[160].c, 7);
        pulse_sync();
        wait_done(700);
        chk("f2_plots", last_plots, 320);
        chk("f2_busy", last_busy, 320);
        repeat (3) step();

        // Row change, with two extra syncs during the draw -> exactly one extra frame.
        y = 7'd92;
        base = n_done;
        model_frame(44, 92);
        model_frame(44, 92);
        pulse_sync();
        repeat (10) step();
        pulse_sync();
        repeat (10) step();
        pulse_sync();
        wait_done(400);
        chk("f3_plots", last_plots, 160);
        wait_done(400);
        chk("f4_plots", last_plots, 160);
        repeat (30) step();
        chk("pending_frames", n_done - base, 2);

        // Right-edge clipping: cols 160..169 hidden, scan length unchanged.
        x = 8'd150; y = 7'd84;
        model_frame(150, 84);
        chk("model_clip_vis", int'(exp_q[9].pl), 1);
        chk("model_clip_hid", int'(exp_q[10].pl), 0);
        pulse_sync();
        wait_done(400);
        chk("clipx_plots", last_plots, 80);
        chk("clipx_busy", last_busy, 160);
        repeat (3) step();

        // Bottom-edge clipping: rows 120..123 hidden.
        x = 8'd0; y = 7'd116;
        model_frame(0, 116);
        pulse_sync();
        wait_done(400);
        chk("clipy_plots", last_plots, 80);
        chk("clipy_busy", last_busy, 160);
        repeat (3) step();

        // Game over mid-draw: draw completes, then red fill.
        x = 8'd20; y = 7'd76;
        model_frame(20, 76);
        model_clear(2'b10);
        pulse_sync();
        repeat (30) step();
        game_status = 2'b10;
        wait_done(400);
        chk("go_draw_plots", last_plots, 160);
        wait_done(20000);
        chk("go_clear_plots", last_plots, 19200);

        // Syncs are ignored while the game is over.
        base = n_done;
        repeat (3) begin
            pulse_sync();
            repeat (30) step();
        end
        chk("go_no_frames", n_done - base, 0);
        chk("go_idle_busy", int'(busy), 0);
        chk("model_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
